// File: rtl/parity_frame_checker_pkg.sv
// Shared definitions for the serial parity frame checker and its generator counterpart.
//   state_e   : deframer FSM states (encodings fixed so both ends of the link agree)
//   START_BIT : line level of a start bit
//   STOP_BIT  : line level of a valid stop bit
package parity_frame_checker_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2,
        StStop   = 2'd3
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// 1-bit XOR accumulator shared by the parity generator and checker.
//   clk      : clock, all updates on posedge
//   rst      : synchronous active-high reset, clears acc to 0
//   init     : load init_val (takes priority over en)
//   init_val : value loaded on init (0 = even, 1 = odd parity)
//   en       : fold bit_in into the running XOR
//   bit_in   : bit to fold
//   acc      : current accumulator value
module parity_accum (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic init_val,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    logic acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 1'b0;
        end else if (init) begin
            acc_q <= init_val;
        end else if (en) begin
            acc_q <= acc_q ^ bit_in;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/parity_frame_checker.sv
// Serial receive-side parity checker. Deframes start(0), DATA_W data bits LSB-first,
// one parity bit and stop(1), then presents the word with parity and framing status.
//   clk        : clock, all state changes on posedge
//   rst        : synchronous active-high reset
//   sample_en  : bit-rate tick; the line is sampled only when high
//   rx_in      : serial line, idle high
//   data_out   : last received word (LSB = first data bit)
//   data_valid : one-cycle pulse when a frame completes
//   parity_err : parity status of the last completed frame (1 = mismatch)
//   frame_err  : stop-bit status of the last completed frame (1 = stop sampled 0)
//   busy       : high whenever a frame is in progress
module parity_frame_checker
    import parity_frame_checker_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              valid_q, valid_d;

    logic acc_init;
    logic acc_en;
    logic acc;

    // After the parity sample the accumulator holds the pending error and stays
    // frozen through STOP, so it doubles as the pending-error register.
    parity_accum u_accum (
        .clk      (clk),
        .rst      (rst),
        .init     (acc_init),
        .init_val (PARITY_ODD),
        .en       (acc_en),
        .bit_in   (rx_in),
        .acc      (acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        valid_d  = 1'b0;
        acc_init = 1'b0;
        acc_en   = 1'b0;

        if (sample_en) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_in == START_BIT) begin
                        state_d  = StData;
                        cnt_d    = '0;
                        acc_init = 1'b1;
                    end
                end
                StData: begin
                    // Right shift: first bit on the line ends up in the LSB.
                    shift_d = (shift_q >> 1) | (DATA_W'(rx_in) << (DATA_W - 1));
                    acc_en  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    acc_en  = 1'b1;
                    state_d = StStop;
                end
                StStop: begin
                    data_d  = shift_q;
                    perr_d  = acc;
                    ferr_d  = (rx_in != STOP_BIT);
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench: an even-parity and an odd-parity checker share one serial line.
// A frame-level model predicts all outputs every cycle; directed frames add literal checks.
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       se  = 1'b0;
    logic       rx  = 1'b1;

    logic [7:0] e_data, o_data;
    logic       e_valid, o_valid, e_perr, o_perr, e_ferr, o_ferr, e_busy, o_busy;

    int checks   = 0;
    int failures = 0;
    bit running  = 1'b1;

    always #5 clk = ~clk;

    parity_frame_checker #(.DATA_W(8), .PARITY_ODD(1'b0)) u_even (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (se),
        .rx_in      (rx),
        .data_out   (e_data),
        .data_valid (e_valid),
        .parity_err (e_perr),
        .frame_err  (e_ferr),
        .busy       (e_busy)
    );

    parity_frame_checker #(.DATA_W(8), .PARITY_ODD(1'b1)) u_odd (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (se),
        .rx_in      (rx),
        .data_out   (o_data),
        .data_valid (o_valid),
        .parity_err (o_perr),
        .frame_err  (o_ferr),
        .busy       (o_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // pos: -1 idle, 0..7 data bit index, 8 parity, 9 stop.
    int         m_pos = -1;
    int         m_bits[8];
    int         m_pbit;
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_perr_e = 1'b0, m_perr_o = 1'b0, m_ferr = 1'b0;

    always @(posedge clk) begin
        int word, ones;
        m_valid = 1'b0;
        if (rst) begin
            m_pos = -1; m_data = 8'h00; m_perr_e = 1'b0; m_perr_o = 1'b0; m_ferr = 1'b0;
        end else if (se) begin
            if (m_pos == -1) begin
                if (rx == 1'b0) m_pos = 0;
            end else if (m_pos < 8) begin
                m_bits[m_pos] = int'(rx);
                m_pos++;
            end else if (m_pos == 8) begin
                m_pbit = int'(rx);
                m_pos  = 9;
            end else begin
                word = 0; ones = 0;
                for (int i = 0; i < 8; i++) begin
                    word += m_bits[i] * (1 << i);
                    ones += m_bits[i];
                end
                // Even checker wants an even total of ones, odd checker an odd total.
                m_data   = word[7:0];
                m_perr_e = ((ones + m_pbit) % 2) != 0;
                m_perr_o = ((ones + m_pbit) % 2) == 0;
                m_ferr   = (rx == 1'b0);
                m_valid  = 1'b1;
                m_pos    = -1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        while (running) begin
            @(posedge clk);
            #1;
            if (!running) break;
            chk("even_data",  32'(e_data),  32'(m_data));
            chk("even_valid", 32'(e_valid), 32'(m_valid));
            chk("even_perr",  32'(e_perr),  32'(m_perr_e));
            chk("even_ferr",  32'(e_ferr),  32'(m_ferr));
            chk("even_busy",  32'(e_busy),  32'(m_pos != -1));
            chk("odd_data",   32'(o_data),  32'(m_data));
            chk("odd_valid",  32'(o_valid), 32'(m_valid));
            chk("odd_perr",   32'(o_perr),  32'(m_perr_o));
            chk("odd_ferr",   32'(o_ferr),  32'(m_ferr));
            chk("odd_busy",   32'(o_busy),  32'(m_pos != -1));
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] g_data;
    logic       g_valid, g_perr_e, g_perr_o, g_ferr;

    // Sends one frame; each bit gets one sample_en tick followed by per-1 idle cycles.
    // Outputs are snapshotted in the cycle right after the stop-bit sample.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int per);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = f[i];
            se = 1'b1;
            @(negedge clk);
            if (i == 10) begin
                g_data = e_data; g_valid = e_valid; g_ferr = e_ferr;
                g_perr_e = e_perr; g_perr_o = o_perr;
            end
            se = 1'b0;
            repeat (per - 1) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        se = 1'b1; rx = 1'b1;
        repeat (n) @(negedge clk);
        se = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy",  32'(e_busy),  32'd0);
        chk("reset_data",  32'(e_data),  32'd0);
        chk("reset_valid", 32'(e_valid), 32'd0);
        rst = 1'b0;
        idle(2);

        // 1: 0xA5, four ones, even parity bit 0
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        chk("t1_data",  32'(g_data),   32'hA5);
        chk("t1_valid", 32'(g_valid),  32'd1);
        chk("t1_perr",  32'(g_perr_e), 32'd0);
        chk("t1_ferr",  32'(g_ferr),   32'd0);
        @(negedge clk);
        chk("t1_pulse_end", 32'(e_valid), 32'd0);
        idle(2);

        // 2: wrong parity on 0xA5; 0x07 with parity 1 is even-correct
        send_frame(8'hA5, 1'b1, 1'b1, 1);
        chk("t2a_data",   32'(g_data),   32'hA5);
        chk("t2a_perr",   32'(g_perr_e), 32'd1);
        chk("t2a_perr_o", 32'(g_perr_o), 32'd0);
        chk("t2a_ferr",   32'(g_ferr),   32'd0);
        send_frame(8'h07, 1'b1, 1'b1, 1);
        chk("t2b_perr",   32'(g_perr_e), 32'd0);
        chk("t2b_perr_o", 32'(g_perr_o), 32'd1);
        idle(1);

        // 3: stop bit sampled 0, then an immediate start bit
        send_frame(8'h5A, 1'b0, 1'b0, 1);
        chk("t3_data", 32'(g_data),   32'h5A);
        chk("t3_ferr", 32'(g_ferr),   32'd1);
        chk("t3_perr", 32'(g_perr_e), 32'd0);
        rx = 1'b0; se = 1'b1;
        @(negedge clk);
        chk("t3_restart_busy", 32'(e_busy), 32'd1);

        // 4: reset after the 3rd data bit of that frame
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; rx = 1'b0;
        @(negedge clk);
        chk("t4_busy",  32'(e_busy),  32'd0);
        chk("t4_valid", 32'(e_valid), 32'd0);
        chk("t4_data",  32'(e_data),  32'd0);
        chk("t4_ferr",  32'(e_ferr),  32'd0);
        rst = 1'b0; se = 1'b0; rx = 1'b1;
        idle(2);
        send_frame(8'h3C, 1'b0, 1'b1, 1);
        chk("t4_clean_data", 32'(g_data),   32'h3C);
        chk("t4_clean_perr", 32'(g_perr_e), 32'd0);
        chk("t4_clean_ferr", 32'(g_ferr),   32'd0);
        idle(2);

        // 5: tick every 4th cycle
        send_frame(8'hC3, 1'b0, 1'b1, 4);
        chk("t5_data",  32'(g_data),   32'hC3);
        chk("t5_valid", 32'(g_valid),  32'd1);
        chk("t5_perr",  32'(g_perr_e), 32'd0);
        chk("t5_ferr",  32'(g_ferr),   32'd0);
        chk("t5_hold_valid", 32'(e_valid), 32'd0);
        chk("t5_hold_data",  32'(e_data),  32'hC3);
        idle(2);

        // 6: odd-parity checker, then back-to-back frames
        send_frame(8'h00, 1'b1, 1'b1, 1);
        chk("t6a_perr_o", 32'(g_perr_o), 32'd0);
        chk("t6a_perr_e", 32'(g_perr_e), 32'd1);
        send_frame(8'h00, 1'b0, 1'b1, 1);
        chk("t6b_perr_o", 32'(g_perr_o), 32'd1);
        idle(1);
        send_frame(8'h01, 1'b0, 1'b1, 1);
        chk("t6c_valid",  32'(g_valid),  32'd1);
        chk("t6c_data",   32'(g_data),   32'h01);
        chk("t6c_perr_o", 32'(g_perr_o), 32'd0);
        send_frame(8'hFE, 1'b0, 1'b1, 1);
        chk("t6d_valid",  32'(g_valid),  32'd1);
        chk("t6d_data",   32'(g_data),   32'hFE);
        chk("t6d_perr_o", 32'(g_perr_o), 32'd0);
        idle(4);

        running = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
